// File: rtl/regwrite_arbiter_pkg.sv
// Shared encodings and limits for the register-file write-port arbiter.
package regwrite_arbiter_pkg;

  typedef enum logic [1:0] {
    DST_RT   = 2'b00,
    DST_RD   = 2'b01,
    DST_LINK = 2'b10,
    DST_NONE = 2'b11
  } dst_sel_e;

  localparam logic [4:0] LINK_REG   = 5'd31;
  localparam int         FIFO_DEPTH = 2;
  localparam int         AGE_W      = 3;
  localparam logic [AGE_W-1:0] AGE_LIMIT = 3'd3;
  localparam logic [AGE_W-1:0] AGE_MAX   = '1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } mc_entry_t;

  function automatic logic [31:0] reg_onehot(input logic [4:0] r);
    return 32'd1 << r;
  endfunction

endpackage

// File: rtl/regwrite_fifo2.sv
// Two-entry buffer for multi-cycle results waiting for the register-file write port.
module regwrite_fifo2
  import regwrite_arbiter_pkg::*;
(
  input  logic      Clk,
  input  logic      Rst_n,
  input  logic      push,
  input  mc_entry_t push_entry,
  input  logic      pop,
  output logic [1:0] count,
  output mc_entry_t head
);

  logic      wr_ptr;
  logic      rd_ptr;
  mc_entry_t mem [FIFO_DEPTH];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: data storage is left unreset; count and pointers alone decide what is valid.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/regwrite_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and
// buffered multi-cycle results, and keeps the pending-destination scoreboard.
module regwrite_arbiter
  import regwrite_arbiter_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        wb_valid,
  input  logic [1:0]  wb_dst_sel,
  input  logic [4:0]  wb_rt,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mc_issue,
  input  logic [4:0]  mc_issue_reg,
  input  logic        mc_valid,
  input  logic [4:0]  mc_reg,
  input  logic [31:0] mc_data,
  output logic        mc_ready,
  input  logic [4:0]  chk_rs,
  input  logic [4:0]  chk_rt,
  input  logic [4:0]  chk_rd,
  output logic        hz_stall,
  output logic        bub_req,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] busy_mask
);

  logic             wb_write;
  logic [4:0]       wb_dst;
  logic [1:0]       fifo_count;
  logic             fifo_ne;
  logic             push;
  logic             grant_mc;
  mc_entry_t        head;
  logic [AGE_W-1:0] age;
  logic [31:0]      set_mask;
  logic [31:0]      clr_mask;

  assign wb_write = wb_valid && (wb_dst_sel != DST_NONE);
  assign fifo_ne  = (fifo_count != 2'd0);
  assign mc_ready = (fifo_count < 2'(FIFO_DEPTH));
  assign push     = mc_valid && mc_ready;
  assign grant_mc = !wb_write && fifo_ne;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wb_dst = '0;
    case (wb_dst_sel)
      DST_RT:   wb_dst = wb_rt;
      DST_RD:   wb_dst = wb_rd;
      DST_LINK: wb_dst = LINK_REG;
      default:  wb_dst = '0;
    endcase
  end

  regwrite_fifo2 u_fifo (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .push       (push),
    .push_entry ('{rd: mc_reg, data: mc_data}),
    .pop        (grant_mc),
    .count      (fifo_count),
    .head       (head)
  );

  // Writes to $0 are dropped here, yet a $0 head is still popped by grant_mc.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (wb_write) begin
      rf_we    = (wb_dst != 5'd0);
      rf_waddr = wb_dst;
      rf_wdata = wb_data;
    end else if (grant_mc) begin
      rf_we    = (head.rd != 5'd0);
      rf_waddr = head.rd;
      rf_wdata = head.data;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      age <= '0;
    end else if (!fifo_ne || grant_mc) begin
      age <= '0;
    end else if (age != AGE_MAX) begin
      age <= age + 1'b1;
    end
  end

  assign bub_req = (age >= AGE_LIMIT);

  assign set_mask = (mc_issue && mc_issue_reg != 5'd0) ? reg_onehot(mc_issue_reg) : '0;
  assign clr_mask = grant_mc ? reg_onehot(head.rd) : '0;

  // A new reservation outranks the retirement of the same register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) busy_mask <= '0;
    else        busy_mask <= (busy_mask & ~clr_mask) | set_mask;
  end

  always_comb begin
    hz_stall = busy_mask[chk_rs] || busy_mask[chk_rt] || busy_mask[chk_rd];
    if (mc_issue && mc_issue_reg != 5'd0 &&
        (mc_issue_reg == chk_rs || mc_issue_reg == chk_rt || mc_issue_reg == chk_rd))
      hz_stall = 1'b1;
  end

endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 The block SHALL have one clock, Clk; reset is asynchronous and active-low, Rst_n.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
  Clk  in  1  rising-edge clock
  Rst_n  in  1  asynchronous active-low reset
  wb_valid  in  1  pipeline writeback requests a register write this cycle
  wb_dst_sel  in  2  00=rt, 01=rd, 10=$31 (link), 11=no write
  wb_rt, wb_rd  in  5 each  candidate destinations
  wb_data  in  32  writeback data
  mc_issue  in  1  multi-cycle op (mult/div/load-miss) issued; reserves mc_issue_reg
  mc_issue_reg  in  5  reserved destination
  mc_valid  in  1  multi-cycle result offered
  mc_reg  in  5  result destination
  mc_data  in  32  result data
  mc_ready  out  1  result accepted when mc_valid&mc_ready at rising edge
  chk_rs, chk_rt, chk_rd  in  5 each  decode-stage operands/destination for hazard check
  hz_stall  out  1  decode must stall
  bub_req  out  1  request one WB bubble (wb_valid=0) next cycle
  rf_we  out  1  register-file write enable
  rf_waddr  out  5  write address
  rf_wdata  out  32  write data
  busy_mask  out  32  scoreboard, bit i = register i pending

Function
REQ-003 WB destination SHALL be rt, rd or 5'd31 per wb_dst_sel; code 11 SHALL be treated as wb_valid=0.
REQ-004 Accepted mc results SHALL enter a 2-entry FIFO (reg+data); mc_ready SHALL equal (FIFO count < 2), registered-state derived, no combinational path from mc_valid.
REQ-005 Each cycle the write port SHALL be granted combinationally: valid WB write first; otherwise FIFO head if non-empty; otherwise rf_we=0.
REQ-006 rf_we/rf_waddr/rf_wdata SHALL be combinational from the grant; an mc result accepted at edge N SHALL be writable no earlier than cycle N+1.
REQ-007 Any write to register 0 SHALL be suppressed (rf_we=0); a FIFO head for $0 SHALL still pop.
REQ-008 FIFO SHALL pop at the edge ending a cycle in which its head was granted; simultaneous push and pop with count=2 SHALL not be allowed (mc_ready=0) and with count=1 SHALL leave count=1.
REQ-009 An age counter (3-bit, saturating) SHALL count cycles the FIFO head is non-empty and not granted, cleared on pop or when empty; bub_req SHALL assert while age >= 3.
REQ-010 busy_mask bit r SHALL set at the edge where mc_issue=1 and mc_issue_reg=r (r != 0), and clear at the edge where the FIFO head for r is popped; set SHALL win when both occur on the same register in the same cycle.
REQ-011 hz_stall SHALL be combinational: 1 when busy_mask[chk_rs], busy_mask[chk_rt] or busy_mask[chk_rd] is 1, or when mc_issue=1 and mc_issue_reg matches any non-zero chk_* (same-cycle reservation).
REQ-012 FIFO wrap-around SHALL use 1-bit read/write pointers plus 2-bit count; count SHALL never exceed 2.

Reset
REQ-013 Rst_n low SHALL immediately clear FIFO count, pointers, age and busy_mask; outputs then: mc_ready=1, bub_req=0, hz_stall=0 (given no mc_issue), rf_we per WB input only.
REQ-014 Reset mid-operation SHALL discard buffered results with no rf write; FIFO data storage needs no reset.

Structure
REQ-015 Shared package SHALL hold wb_dst_sel encodings (DST_RT, DST_RD, DST_LINK, DST_NONE), LINK_REG=31, FIFO_DEPTH=2, AGE_LIMIT=3.
REQ-016 The FIFO SHALL be one sub-module, regwrite_fifo2 (push/pop/count/head outputs).

Verification
REQ-017 Reset, then wb_valid=1, sel=10, data=0x1234 -> rf_we=1, rf_waddr=31, rf_wdata=0x1234 same cycle.
REQ-018 mc_issue reg 5 -> busy_mask=0x20 next cycle, chk_rs=5 gives hz_stall=1; mc_valid reg 5 data 0xAA with wb idle -> write to 5 next cycle, busy_mask=0 after.
REQ-019 Continuous WB writes, two mc results pushed -> mc_ready=0, bub_req=1 after 3 ungranted cycles; WB bubble -> head written, count=1, age=0.
REQ-020 mc_issue reg 7 in the same cycle the FIFO pops reg 7 -> busy_mask[7]=1 afterward.
REQ-021 wb sel=01, rd=0 and FIFO head reg 0 -> rf_we=0 both cycles, FIFO still pops.
REQ-022 Rst_n low with FIFO count 2 and busy bits set -> count 0, busy_mask=0, no rf write of discarded data.
